// File: rtl/vmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// vmem_port_arbiter
//
// Shares one single-port synchronous vector memory between N_REQ requesters,
// typically the vector load/store lanes. Grant is round-robin. A multi-beat
// burst locks the port to its owner until the beat marked req_last. The port
// carries one access per cycle. Read data comes back tagged with the id of the
// requester that issued the read.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid      per-requester request valid
//   req_ready      per-requester accept (one-hot or zero)
//   req_we         per-requester write enable (1 = write, 0 = read)
//   req_last       per-requester final beat of a burst (1 = single access)
//   req_addr       packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata      packed write data, requester i at [i*MEMORY_BITS +: MEMORY_BITS]
//   resp_valid     read response valid (no backpressure)
//   resp_id        requester that issued the read
//   resp_data      read data
//   mem_we         memory write enable
//   mem_addr       memory address
//   mem_wdata      memory write data
//   mem_rddata     memory read data, valid one cycle after the address
//
// Build option
//   VMEM_ARB_RESP_REG_EN  when defined, the response is registered once more
//                         (fire T -> response T+2). Otherwise the response
//                         arrives in T+1 with resp_data taken from mem_rddata.
// -----------------------------------------------------------------------------
module vmem_port_arbiter #(
   parameter int N_REQ       = 4,
   parameter int MEMORY_BITS = 32,
   parameter int ADDR_RANGE  = 32768,
   localparam int ADDR_W     = $clog2(ADDR_RANGE),
   localparam int ID_W       = $clog2(N_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ-1:0]             req_we,
   input  logic [N_REQ-1:0]             req_last,
   input  logic [N_REQ*ADDR_W-1:0]      req_addr,
   input  logic [N_REQ*MEMORY_BITS-1:0] req_wdata,
   output logic                         resp_valid,
   output logic [ID_W-1:0]              resp_id,
   output logic [MEMORY_BITS-1:0]       resp_data,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [MEMORY_BITS-1:0]       mem_wdata,
   input  logic [MEMORY_BITS-1:0]       mem_rddata
);

   localparam logic [0:0] ST_ARB  = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [0:0]       state;
   logic [ID_W-1:0]  owner;
   logic [ID_W-1:0]  rr_ptr;

   logic [N_REQ-1:0] grant_oh;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W-1:0]  rr_next;
   logic             fire;
   logic             fire_last;
   logic             rd_fire;

   logic             rsp_v_q;
   logic [ID_W-1:0]  rsp_id_q;

   // ---------------------------------------------------------------------------
   // Grant selection. In ARB the scan starts at rr_ptr and wraps; in LOCK only
   // the burst owner can be granted, and only while it is presenting a request.
   // Grant depends on valid bits only, never on address or data.
   // ---------------------------------------------------------------------------
   always_comb begin
      int unsigned idx;
      logic        found;
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      if (state == ST_LOCK) begin
         if (req_valid[owner]) begin
            grant_oh[owner] = 1'b1;
            grant_idx       = owner;
         end
      end else begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
               found          = 1'b1;
               grant_oh[idx]  = 1'b1;
               grant_idx      = ID_W'(idx);
            end
         end
      end
   end

   // Ready is forced low for the whole time reset is asserted, not just after
   // the first clock edge, so nothing can fire while rst_n is low.
   assign req_ready = rst_n ? grant_oh : '0;
   assign fire      = |req_ready;
   assign fire_last = fire & req_last[grant_idx];
   assign rr_next   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // ---------------------------------------------------------------------------
   // Memory port: combinational from the granted requester, zero when idle.
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (fire) begin
         mem_we    = req_we[grant_idx];
         mem_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
         mem_wdata = req_wdata[int'(grant_idx)*MEMORY_BITS +: MEMORY_BITS];
      end
   end

   assign rd_fire = fire & ~req_we[grant_idx];

   // ---------------------------------------------------------------------------
   // Arbitration state. The round-robin pointer moves only when a transfer
   // completes (single access or final burst beat), so a burst never perturbs
   // the fairness order.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_ARB;
         owner  <= '0;
         rr_ptr <= '0;
      end else if (fire_last) begin
         state  <= ST_ARB;
         rr_ptr <= rr_next;
      end else if (fire) begin
         state  <= ST_LOCK;
         owner  <= grant_idx;
      end
   end

   // First response stage: tags the read that goes to memory this cycle. The
   // memory returns its data one cycle later, aligned with this register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_v_q  <= 1'b0;
         rsp_id_q <= '0;
      end else begin
         rsp_v_q  <= rd_fire;
         rsp_id_q <= rd_fire ? grant_idx : rsp_id_q;
      end
   end

`ifdef VMEM_ARB_RESP_REG_EN
   logic                   rsp_v_r;
   logic [ID_W-1:0]        rsp_id_r;
   logic [MEMORY_BITS-1:0] rsp_data_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_v_r    <= 1'b0;
         rsp_id_r   <= '0;
         rsp_data_r <= '0;
      end else begin
         rsp_v_r    <= rsp_v_q;
         rsp_id_r   <= rsp_v_q ? rsp_id_q : rsp_id_r;
         rsp_data_r <= rsp_v_q ? mem_rddata : rsp_data_r;
      end
   end

   assign resp_valid = rsp_v_r;
   assign resp_id    = rsp_id_r;
   assign resp_data  = rsp_data_r;
`else
   assign resp_valid = rsp_v_q;
   assign resp_id    = rsp_id_q;
   // Gated by the valid flag so idle cycles and reset present zero data
   // rather than whatever the memory is driving.
   assign resp_data  = rsp_v_q ? mem_rddata : '0;
`endif

endmodule

// File: tb/tb_vmem_port_arbiter.sv
module tb_vmem_port_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AR = 32768;
   localparam int AW = 15;
   localparam int IW = 2;
`ifdef VMEM_ARB_RESP_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready, req_we, req_last;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic            resp_valid;
   logic [IW-1:0]   resp_id;
   logic [DW-1:0]   resp_data;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rddata;

   logic [DW-1:0]   mem [0:AR-1];

   always #5 clk = ~clk;

   vmem_port_arbiter #(.N_REQ(N), .MEMORY_BITS(DW), .ADDR_RANGE(AR)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rddata(mem_rddata)
   );

   // Single-port synchronous memory, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rddata <= mem[mem_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      req_valid = '0;
      req_we    = '0;
      req_last  = '0;
   endtask

   task automatic set_req(input int i, input logic v, input logic we, input logic last,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]          = v;
      req_we[i]             = we;
      req_last[i]           = last;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   // Called in the cycle after a read fire; idles and checks the response
   // appears exactly LAT cycles after the fire.
   task automatic idle_expect_resp(input int id, input logic [DW-1:0] d);
      clear_req();
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (k < LAT) begin
            chk("resp_early", 64'(resp_valid), 64'd0);
         end else begin
            chk("resp_valid", 64'(resp_valid), 64'd1);
            chk("resp_id", 64'(resp_id), 64'(id));
            chk("resp_data", 64'(resp_data), 64'(d));
         end
         tick();
      end
   endtask

   typedef struct {
      logic [N-1:0] valid;
      logic [N-1:0] we;
      logic [N-1:0] last;
      logic [N-1:0] ready;
   } vec_t;

   vec_t tbl [13];
   logic hv [2];
   int   hid [2];
   int   wr_req [8];
   logic [DW-1:0] wr_dat [8];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Round-robin: all four requesters issue single reads.
      tbl[0]  = '{4'b1111, 4'b0000, 4'b1111, 4'b0001};
      tbl[1]  = '{4'b1111, 4'b0000, 4'b1111, 4'b0010};
      tbl[2]  = '{4'b1111, 4'b0000, 4'b1111, 4'b0100};
      tbl[3]  = '{4'b1111, 4'b0000, 4'b1111, 4'b1000};
      tbl[4]  = '{4'b1111, 4'b0000, 4'b1111, 4'b0001};
      // Burst lock: req1 writes 3 beats, drops valid once mid-burst.
      tbl[5]  = '{4'b0111, 4'b0010, 4'b0101, 4'b0010};
      tbl[6]  = '{4'b0101, 4'b0010, 4'b0101, 4'b0000};
      tbl[7]  = '{4'b0111, 4'b0010, 4'b0101, 4'b0010};
      tbl[8]  = '{4'b0111, 4'b0010, 4'b0111, 4'b0010};
      tbl[9]  = '{4'b0101, 4'b0000, 4'b1111, 4'b0100};
      tbl[10] = '{4'b0101, 4'b0000, 4'b1111, 4'b0001};
      tbl[11] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};
      tbl[12] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};

      wr_req[0] = 2; wr_req[1] = 0; wr_req[2] = 3; wr_req[3] = 1;
      wr_req[4] = 1; wr_req[5] = 2; wr_req[6] = 0; wr_req[7] = 3;

      for (int a = 0; a < AR; a++) mem[a] = '0;

      // ---- Reset with every requester valid ----
      rst_n = 1'b0;
      clear_req();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b1, AW'(32'h100 + i), 32'hA000_0000 + i);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_ready", 64'(req_ready), 64'd0);
         chk("rst_resp_valid", 64'(resp_valid), 64'd0);
         chk("rst_mem_we", 64'(mem_we), 64'd0);
         chk("rst_resp_id", 64'(resp_id), 64'd0);
         chk("rst_resp_data", 64'(resp_data), 64'd0);
      end
      tick();
      rst_n = 1'b1;

      // ---- Table: round-robin, then burst lock ----
      hv[0] = 1'b0; hv[1] = 1'b0; hid[0] = 0; hid[1] = 0;
      for (int r = 0; r < 13; r++) begin
         int  eid;
         logic ef;
         req_valid = tbl[r].valid;
         req_we    = tbl[r].we;
         req_last  = tbl[r].last;
         @(negedge clk);
         eid = 0;
         for (int j = 0; j < N; j++) if (tbl[r].ready[j]) eid = j;
         ef = |tbl[r].ready;
         chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].ready));
         chk($sformatf("tbl%0d_mem_we", r), 64'(mem_we), 64'(ef & tbl[r].we[eid]));
         chk($sformatf("tbl%0d_mem_addr", r), 64'(mem_addr), ef ? 64'(32'h100 + eid) : 64'd0);
         chk($sformatf("tbl%0d_resp_valid", r), 64'(resp_valid), 64'(hv[LAT-1]));
         if (hv[LAT-1]) chk($sformatf("tbl%0d_resp_id", r), 64'(resp_id), 64'(hid[LAT-1]));
         hv[1]  = hv[0];
         hid[1] = hid[0];
         hv[0]  = ef & ~tbl[r].we[eid];
         hid[0] = eid;
         tick();
      end

      // ---- RAW: write then read same address in consecutive cycles ----
      clear_req();
      set_req(0, 1'b1, 1'b1, 1'b1, AW'(32'h10), 32'hDEAD_BEEF);
      @(negedge clk);
      chk("raw_w_ready", 64'(req_ready), 64'd1);
      chk("raw_w_mem_we", 64'(mem_we), 64'd1);
      chk("raw_w_mem_addr", 64'(mem_addr), 64'h10);
      chk("raw_w_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      tick();
      set_req(0, 1'b1, 1'b0, 1'b1, AW'(32'h10), 32'h0);
      @(negedge clk);
      chk("raw_r_ready", 64'(req_ready), 64'd1);
      chk("raw_r_mem_we", 64'(mem_we), 64'd0);
      chk("raw_w_no_resp", 64'(resp_valid), 64'd0);
      tick();
      idle_expect_resp(0, 32'hDEAD_BEEF);

      // ---- Reset mid-burst ----
      // Single read by req1 moves rr_ptr to 2 first, so a surviving pointer
      // would grant req2 instead of req0 after reset.
      clear_req();
      set_req(1, 1'b1, 1'b0, 1'b1, AW'(32'h101), 32'h0);
      @(negedge clk);
      chk("pre_ready", 64'(req_ready), 64'b0010);
      tick();
      idle_expect_resp(1, 32'hA000_0001);
      clear_req();
      set_req(3, 1'b1, 1'b1, 1'b0, AW'(32'h20), 32'h3333_3333);
      @(negedge clk);
      chk("burst_b1_ready", 64'(req_ready), 64'b1000);
      tick();
      set_req(3, 1'b1, 1'b0, 1'b0, AW'(32'h20), 32'h0);
      set_req(0, 1'b1, 1'b0, 1'b1, AW'(32'h100), 32'h0);
      set_req(2, 1'b1, 1'b0, 1'b1, AW'(32'h102), 32'h0);
      @(negedge clk);
      chk("burst_b2_ready", 64'(req_ready), 64'b1000);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 64'(req_ready), 64'd0);
      chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
      chk("midrst_mem_we", 64'(mem_we), 64'd0);
      tick();
      rst_n = 1'b1;
      clear_req();
      set_req(0, 1'b1, 1'b0, 1'b1, AW'(32'h100), 32'h0);
      set_req(2, 1'b1, 1'b0, 1'b1, AW'(32'h102), 32'h0);
      set_req(3, 1'b1, 1'b0, 1'b1, AW'(32'h20), 32'h0);
      @(negedge clk);
      chk("postrst_ready", 64'(req_ready), 64'b0001);
      chk("postrst_resp_valid", 64'(resp_valid), 64'd0);
      tick();
      idle_expect_resp(0, 32'h0);

      // ---- Write-only traffic from mixed requesters, then readback ----
      for (int k = 0; k < 8; k++) begin
         wr_dat[k] = 32'hC0DE_0000 + 32'(k) * 32'h1111;
         clear_req();
         set_req(wr_req[k], 1'b1, 1'b1, 1'b1, AW'(32'h200 + k), wr_dat[k]);
         @(negedge clk);
         chk($sformatf("wr%0d_ready", k), 64'(req_ready), 64'(4'b0001 << wr_req[k]));
         chk($sformatf("wr%0d_mem_we", k), 64'(mem_we), 64'd1);
         chk($sformatf("wr%0d_resp_valid", k), 64'(resp_valid), 64'd0);
         tick();
      end
      clear_req();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("wr_tail_resp_valid", 64'(resp_valid), 64'd0);
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         int rq;
         rq = (k + 1) % N;
         clear_req();
         set_req(rq, 1'b1, 1'b0, 1'b1, AW'(32'h200 + k), 32'h0);
         @(negedge clk);
         chk($sformatf("rd%0d_ready", k), 64'(req_ready), 64'(4'b0001 << rq));
         tick();
         idle_expect_resp(rq, wr_dat[k]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
